mov_engine: RTL

//  Parametrised block-move engine that executes the MIX MOVE instruction.

---
 rtl/mix_pkg.sv | 9 +
 rtl/mov_addr_gen.sv | 55 +++++
 rtl/mov_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mix_pkg.sv
// Shared types and default widths for the MIX block-move engine.
// Contents: MIX_ADDR_W / MIX_WORD_W / MIX_LEN_W defaults and the mov_state_t FSM encoding.
package mix_pkg;
   localparam int MIX_ADDR_W = 12;
   localparam int MIX_WORD_W = 31;
   localparam int MIX_LEN_W  = 6;

   typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} mov_state_t;
endpackage

// File: rtl/mov_addr_gen.sv
// One memory pointer for the move engine (used for both source and destination).
// On load it starts at base (ascending) or base+len-1 (descending). Each step moves it
// by one word in the latched direction. Arithmetic wraps modulo 2**ADDR_W.
// Ports:
//   clk_i, reset_i   clock, async active-high reset
//   ld_i             load the pointer from base_i/len_i/desc_i
//   desc_i           direction at load time (1 = descending)
//   step_i           advance the pointer one word
//   base_i, len_i    first address and word count of the move
//   ptr_o            current pointer (register output)
module mov_addr_gen
   import mix_pkg::*;
#(
   parameter int ADDR_W = MIX_ADDR_W,
   parameter int LEN_W  = MIX_LEN_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ld_i,
   input  logic              desc_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [ADDR_W-1:0] ptr_o
);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] ptr_q, ptr_d, len_ext;
   logic              desc_q, desc_d;

   assign len_ext = {{(ADDR_W-LEN_W){1'b0}}, len_i};

   always_comb begin
      ptr_d  = ptr_q;
      desc_d = desc_q;
      if (ld_i) begin
         desc_d = desc_i;
         ptr_d  = desc_i ? (base_i + len_ext - ONE) : base_i;
      end else if (step_i) begin
         ptr_d  = desc_q ? (ptr_q - ONE) : (ptr_q + ONE);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q  <= '0;
         desc_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         desc_q <= desc_d;
      end
   end

   assign ptr_o = ptr_q;
endmodule

// File: rtl/mov_engine.sv
// MIX MOVE block-move engine: copies len_i words from src_addr_i to dst_addr_i using one
// read port and one write port. Copies descending when the destination overlaps the upper
// part of the source, so overlapping moves are correct.
// Build option: MOV_PIPE_EN overlaps reads and writes (1 word/cycle, start->done = len+2);
// without it reads and writes alternate (1 word/2 cycles, start->done = 2*len+1).
// Ports:
//   clk_i, reset_i            clock, async active-high reset
//   start_i, abort_i          move request (IDLE only) / early termination
//   src_addr_i, dst_addr_i    first source / destination address
//   len_i                     number of words
//   busy_o, done_o            move in progress / one-cycle completion pulse
//   mem_rd_o, mem_rd_addr_o   read strobe and address; mem_rd_data_i valid one cycle later
//   mem_wr_o, mem_wr_addr_o   write strobe and address
//   mem_wr_data_o             combinational copy of mem_rd_data_i
module mov_engine
   import mix_pkg::*;
#(
   parameter int ADDR_W = MIX_ADDR_W,
   parameter int LEN_W  = MIX_LEN_W,
   parameter int DATA_W = MIX_WORD_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_rd_addr_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_wr_addr_o,
   output logic [DATA_W-1:0] mem_wr_data_o
);
   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   mov_state_t       state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             rd_q, rd_d, wr_q, wr_d;
   logic             abort_q, abort_d, ab;
   logic             ld, src_step, dst_step, desc;
   logic [ADDR_W:0]  src_x, dst_x, end_x;

   // Overlap test done one bit wider so src+len never wraps.
   assign src_x = {1'b0, src_addr_i};
   assign dst_x = {1'b0, dst_addr_i};
   assign end_x = src_x + {{(ADDR_W+1-LEN_W){1'b0}}, len_i};
   assign desc  = (dst_x > src_x) && (dst_x < end_x);

   assign ld = (state_q == IDLE) && start_i && (len_i != '0);
   // A one-cycle abort pulse must survive until the pending write retires.
   assign ab = abort_q | abort_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      abort_d  = abort_q;
      src_step = 1'b0;
      dst_step = 1'b0;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (start_i) begin
               if (len_i != '0) begin
                  cnt_d   = len_i;
                  busy_d  = 1'b1;
                  rd_d    = 1'b1;
                  state_d = READ;
               end else begin
                  done_d  = 1'b1;
                  state_d = FINISH;
               end
            end
         end
`ifdef MOV_PIPE_EN
         // cnt counts reads still to issue, including the one on the bus now.
         READ: begin
            if (abort_i) abort_d = 1'b1;
            src_step = 1'b1;
            dst_step = wr_q;
            cnt_d    = cnt_q - CNT_ONE;
            wr_d     = 1'b1;
            if ((cnt_q > CNT_ONE) && !ab) begin
               rd_d = 1'b1;
            end else begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            dst_step = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = FINISH;
         end
`else
         READ: begin
            if (abort_i) abort_d = 1'b1;
            src_step = 1'b1;
            wr_d     = 1'b1;
            state_d  = WRITE;
         end
         // cnt counts words not yet written, including the one on the bus now.
         WRITE: begin
            dst_step = 1'b1;
            cnt_d    = cnt_q - CNT_ONE;
            if ((cnt_q > CNT_ONE) && !ab) begin
               rd_d    = 1'b1;
               state_d = READ;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = FINISH;
            end
         end
`endif
         FINISH: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         abort_q <= abort_d;
      end
   end

   mov_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_src (
      .clk_i(clk_i), .reset_i(reset_i), .ld_i(ld), .desc_i(desc), .step_i(src_step),
      .base_i(src_addr_i), .len_i(len_i), .ptr_o(mem_rd_addr_o)
   );

   mov_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dst (
      .clk_i(clk_i), .reset_i(reset_i), .ld_i(ld), .desc_i(desc), .step_i(dst_step),
      .base_i(dst_addr_i), .len_i(len_i), .ptr_o(mem_wr_addr_o)
   );

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign mem_rd_o      = rd_q;
   assign mem_wr_o      = wr_q;
   assign mem_wr_data_o = mem_rd_data_i;
endmodule
